alu_div: RTL
============

# alu_div

Sequential 32-bit integer divider paired with the single-cycle `alu`. The ALU performs multiplication combinationally; this unit performs the inverse operation. It divides iteratively at one quotient bit per cycle, using a start/busy/done handshake. The CPU control sequencer stalls issue while `busy` is high and writes `quotient` or `remainder` back to the register file on `done`.

## Interface
- `DW`, 32: operand, quotient and remainder width in bits. The iteration count equals `DW`.
- `clk`  in  1: single clock. All state updates on the rising edge.
- `reset_b`  in  1: asynchronous, active-low reset.
- `start`  in  1: request. Sampled only in IDLE.
- `signed_op`  in  1: 1 selects two's-complement division, 0 selects unsigned. Sampled with `start`.
- `din_a`  in  DW: dividend. Sampled with `start`.
- `din_b`  in  DW: divisor. Sampled with `start`.
- `busy`  out  1: high while a division is in progress.
- `done`  out  1: one-cycle pulse marking that the result is valid.
- `quotient`  out  DW: result quotient. Held until the next accepted `start`.
- `remainder`  out  DW: result remainder. Held until the next accepted `start`.
- `dz`  out  1: divide-by-zero flag for the last result.
- `vout`  out  1: signed overflow flag for the last result.

## Operation
- States: IDLE, CALC, FIX.
- **Reset.**
  - The block enters IDLE.
  - `busy`, `done`, `dz` and `vout` are 0.
  - `quotient` and `remainder` are 0.
  - The iteration counter is 0.
- **IDLE with `start` = 1 and `din_b` != 0.**
  - Latch the magnitudes of both operands. In signed mode, negate an operand whose MSB is set. In unsigned mode, use the operands as-is.
  - Latch `neg_q = signed_op & (a[DW-1] ^ b[DW-1])`.
  - Latch `neg_r = signed_op & a[DW-1]`.
  - Clear the partial remainder (DW+1 bits).
  - Set `counter = DW-1`, `busy = 1`, and go to CALC.
- **IDLE with `start` = 1 and `din_b` == 0.**
  - Go straight to the result, with no iteration.
  - `quotient` = all ones, `remainder = din_a` unchanged, `dz = 1`, `vout = 0`.
  - `done = 1` on the next cycle. `busy` stays 0.
- **CALC (restoring algorithm), each cycle:**
  - Shift the partial remainder left by 1 and bring in the dividend MSB.
  - Trial subtract the divisor. If the result is non-negative, keep the difference and shift a 1 into the quotient. Otherwise keep the shifted value and shift a 0 into the quotient.
  - Decrement the counter. At `counter == 0`, go to FIX.
- **FIX:**
  - `quotient` = neg_q ? −q : q.
  - `remainder` = neg_r ? −r : r.
  - `dz = 0`.
  - `vout = signed_op & (din_a == 2^(DW-1)) & (din_b == all-ones)`, using the operands latched at start.
  - Pulse `done = 1`, drop `busy`, and return to IDLE.
- **Result rules:**
  - The quotient truncates toward zero.
  - The remainder takes the sign of the dividend.
  - Overflow case: the quotient wraps naturally to 0x80000000 and the remainder is 0.
- **`start` while `busy`** is ignored. Operands and results are not disturbed.
- **`start` during the `done` cycle** is accepted, because the block is already in IDLE. This allows back-to-back divisions.
- **Reset mid-operation** aborts immediately. All outputs take their reset values and no `done` is produced.

## Timing
- Let edge 0 be the rising edge at which `start` is sampled in IDLE.
- Normal divide:
  - `busy` is high from after edge 0 through edge DW+1.
  - CALC occupies edges 1..DW. FIX is at edge DW+1.
  - `done` and the new results are visible in the cycle after edge DW+1. That is a latency of DW+1 = 33 cycles for DW = 32.
  - `busy` falls on the same edge that `done` rises.
- Divide by zero: `done` and the results are visible after edge 0, a latency of 1 cycle.
- `done` is exactly one cycle wide and is registered. There is no combinational path from inputs to outputs.
- `quotient`, `remainder`, `dz` and `vout` change only on the edge that raises `done`, or on reset.

## Test plan
- **Unsigned basic.** `signed_op=0`, 100 / 7.
  - Required: `quotient=14`, `remainder=2`, `dz=0`, `vout=0`.
  - `done` is high exactly 33 cycles after `start`, and `busy` is high for cycles 1..33.
- **Signed sign rules.**
  - −100 / 7 → `quotient=0xFFFFFFF2`, `remainder=0xFFFFFFFE`.
  - 100 / −7 → `quotient=0xFFFFFFF2`, `remainder=2`.
  - Unsigned 0xFFFFFFFF / 2 → `quotient=0x7FFFFFFF`, `remainder=1`.
- **Overflow.** Signed 0x80000000 / 0xFFFFFFFF.
  - Required: `quotient=0x80000000`, `remainder=0`, `vout=1`.
  - The same operands with `signed_op=0` give `quotient=0`, `remainder=0x80000000`, `vout=0`.
- **Divide by zero.** 5 / 0.
  - Required: `done` is high 1 cycle after `start`, with `quotient=0xFFFFFFFF`, `remainder=5`, `dz=1`, and `busy` never asserted.
- **Handshake.**
  - Start 100 / 7, then pulse `start` with 9 / 3 at cycle 10. The second start is ignored and the result is still 14 r 2.
  - Then assert 9 / 3 during the `done` cycle. It is accepted, giving `quotient=3`, `remainder=0` 33 cycles later.
- **Reset mid-operation.**
  - Assert `reset_b=0` at cycle 12 of a division. `busy` and all outputs go to 0 immediately, and no `done` is produced.
  - After release, 100 / 7 completes normally.

Source files
------------

// File: rtl/alu_div.sv
// Sequential restoring divider: one quotient bit per cycle, start/busy/done handshake.
// A zero divisor returns all-ones / dividend with dz set, after one cycle.
//
//   state | meaning
//   IDLE  | waiting for start; a zero divisor is answered here directly
//   CALC  | one restoring iteration per cycle, DW cycles in total
//   FIX   | applies the result signs, publishes results, pulses done
module alu_div #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset_b,
  input  logic          start,
  input  logic          signed_op,
  input  logic [DW-1:0] din_a,
  input  logic [DW-1:0] din_b,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [DW-1:0] remainder,
  output logic          dz,
  output logic          vout
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [DW-1:0] MIN_NEG  = {1'b1, {(DW-1){1'b0}}};

  state_t        state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dvd;   // dividend shifts out the top while quotient bits enter the bottom
  logic [DW-1:0] dsr;
  logic [DW-1:0] prem;
  logic          neg_q;
  logic          neg_r;
  logic          ovf;

  logic [DW-1:0] a_mag;
  logic [DW-1:0] b_mag;
  logic [DW:0]   shifted;
  logic [DW:0]   diff;

  assign a_mag = (signed_op && din_a[DW-1]) ? -din_a : din_a;
  assign b_mag = (signed_op && din_b[DW-1]) ? -din_b : din_b;

  // The partial remainder stays below the divisor between iterations, so only
  // the shifted trial value needs the extra (DW+1)th bit.
  assign shifted = {prem, dvd[DW-1]};
  assign diff    = shifted - {1'b0, dsr};

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state     <= IDLE;
      cnt       <= '0;
      dvd       <= '0;
      dsr       <= '0;
      prem      <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      ovf       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dz        <= 1'b0;
      vout      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (din_b == '0) begin
              quotient  <= '1;
              remainder <= din_a;
              dz        <= 1'b1;
              vout      <= 1'b0;
              done      <= 1'b1;
            end else begin
              dvd   <= a_mag;
              dsr   <= b_mag;
              prem  <= '0;
              neg_q <= signed_op & (din_a[DW-1] ^ din_b[DW-1]);
              neg_r <= signed_op & din_a[DW-1];
              ovf   <= signed_op & (din_a == MIN_NEG) & (din_b == '1);
              cnt   <= CNT_LAST;
              busy  <= 1'b1;
              state <= CALC;
            end
          end
        end
        CALC: begin
          prem <= diff[DW] ? shifted[DW-1:0] : diff[DW-1:0];
          dvd  <= {dvd[DW-2:0], ~diff[DW]};
          cnt  <= cnt - CNT_ONE;
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          quotient  <= neg_q ? -dvd : dvd;
          remainder <= neg_r ? -prem : prem;
          dz        <= 1'b0;
          vout      <= ovf;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
